data_bus_master: RTL and testbench
==================================

# data_bus_master

Core-side initiator for the 16-bit peripheral data bus. It accepts byte, halfword and word load/store requests from the CPU pipeline. It performs them as one or two single-cycle halfword bus transactions, using read-modify-write for byte stores because the bus has no byte enables. It returns extended load data or an alignment error, and is the sole driver of the bus that peripherals such as the GPIO port respond to.

## Interface
Parameters: none.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready
- req_write  in  1  1 store, 0 load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: zero-extend (1) or sign-extend (0)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_error  out  1  valid with resp_valid: misaligned or illegal size
- resp_rdata  out  32  load result; 0 for stores and errors
- data_bus_addr  out  32  halfword-aligned byte address, bit 0 always 0
- data_bus_mode  out  2  00 none, 01 read, 10 write
- data_bus_select  out  1  high exactly when mode is not 00
- data_bus_write  out  16  write data, valid when mode is 10
- data_bus_read  in  16  responder data, combinational from addr, sampled at end of read cycle

## Operation
- FSM states:
  - IDLE
  - READ_LO: load halfword/byte, or low half of a word
  - READ_HI: high half of a word
  - WRITE_LO
  - WRITE_HI
  - RMW_READ
  - RMW_WRITE
  - ERROR
- Bus outputs are decoded from the state and captured request registers only (Moore). In IDLE and ERROR: mode 00, select 0, addr 0, write data 0.
- On accept, capture the request. Error check happens first: halfword with addr[0]=1, word with addr[1:0]≠0, or size 11 goes to ERROR. No bus cycle is issued.
- Transitions by request type:
  - Load byte/half: READ_LO→IDLE.
  - Load word: READ_LO (addr)→READ_HI (addr+2)→IDLE.
  - Store half: WRITE_LO→IDLE.
  - Store word: WRITE_LO (wdata[15:0] @addr)→WRITE_HI (wdata[31:16] @addr+2)→IDLE.
  - Store byte: RMW_READ→RMW_WRITE→IDLE. RMW_READ reads the halfword at {addr[31:1],0}. RMW_WRITE replaces byte addr[0] (0 = [7:0], 1 = [15:8]) with wdata[7:0] and writes it back.
  - ERROR→IDLE.
- Load extraction:
  - Byte = addr[0] ? hw[15:8] : hw[7:0].
  - Byte and halfword results are sign- or zero-extended per req_unsigned.
  - Word = {hi, lo}, little-endian.
- Byte loads use {addr[31:1],0} on the bus.
- addr+2 uses 32-bit arithmetic. Aligned words never carry out of bit 31.
- resp_valid, resp_error and resp_rdata are registered. They update on the transition into IDLE from any non-IDLE state and hold otherwise. resp_valid self-clears after one cycle.
- req_valid while busy is ignored; the requester holds it until req_ready.

## Timing
- Reset values:
  - req_ready 1; state IDLE.
  - resp_valid 0, resp_error 0, resp_rdata 0.
  - data_bus_mode 00, data_bus_select 0, data_bus_addr 0, data_bus_write 0.
- Each bus transaction lasts exactly one cycle; the bus has no wait states.
- Latency from the accept edge to resp_valid high:
  - byte/half load, half store, error: 2 cycles
  - word load, word store, byte store: 3 cycles
- Back-to-back: in the resp_valid cycle the FSM is in IDLE with req_ready=1. A new request can be accepted in that same cycle, giving full throughput.
- Reset asserted mid-operation: immediate return to IDLE and bus idle. No response is ever produced for the aborted request. A partial word store or RMW may leave the target half-updated; this is accepted behaviour.
- The hi-half read data is sampled on the READ_HI→IDLE edge. The lo half is held in a 16-bit register from the READ_LO edge.

## Structure
- Shared package holds:
  - bus mode constants BUS_NONE=00, BUS_READ=01, BUS_WRITE=10 (also used by peripherals)
  - size constants SIZE_BYTE/HALF/WORD
  - FSM state enum
- No sub-module. Extraction/extension and byte merge are local functions.

## Test plan
- Reset, then idle: all bus outputs 0, req_ready=1, resp_valid=0. Assert reset during READ_HI of a word load → bus idle immediately, no resp_valid after release.
- Word store 0xDEADBEEF to 0x4034 → WRITE 0xBEEF @0x4034, then WRITE 0xDEAD @0x4036 on consecutive cycles. resp_valid 3 cycles after accept, rdata 0.
- Word load 0x4038, responder returning 0x1234 @0x4038 and 0x8765 @0x403A → rdata 0x87651234, latency 3.
- Signed byte load 0x4039, halfword 0x80AA → rdata 0xFFFFFF80. Unsigned → 0x00000080. Signed halfword 0x80AA → 0xFFFF80AA.
- Byte store 0x5C to 0x4038 with existing halfword 0xA1B2 → READ @0x4038, then WRITE 0xA15C. Same store to 0x4039 → WRITE 0x5CB2.
- Halfword load 0x4035, word load 0x4036, size 11 → no bus activity, resp_error=1 at +2. Back-to-back half loads accepted on every resp_valid cycle → one response per 2 cycles.

Source files
------------

// File: rtl/data_bus_master_pkg.sv
// Shared definitions for the 16-bit peripheral data bus and its core-side initiator.
// The bus mode constants are also used by peripherals that respond on the bus.
package data_bus_master_pkg;

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    READ_LO,
    READ_HI,
    WRITE_LO,
    WRITE_HI,
    RMW_READ,
    RMW_WRITE,
    ERROR
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/data_bus_master.sv
// Core-side initiator: turns byte/half/word loads and stores into one or two
// single-cycle halfword bus transactions, with read-modify-write for byte stores.
module data_bus_master
  import data_bus_master_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] data_bus_addr,
  output logic [1:0]  data_bus_mode,
  output logic        data_bus_select,
  output logic [15:0] data_bus_write,
  input  logic [15:0] data_bus_read
);

  state_e      state;
  state_e      state_next;
  req_t        req_q;
  logic [15:0] lo_q;
  logic [31:0] base_addr;
  logic [31:0] hi_addr;

  function automatic logic is_bad_request(input logic [1:0] size, input logic [1:0] addr_lsb);
    return (size == SIZE_ILLEGAL) ||
           (size == SIZE_HALF && addr_lsb[0]) ||
           (size == SIZE_WORD && addr_lsb != 2'b00);
  endfunction

  function automatic logic [31:0] extend_load(input logic [15:0] hw, input logic [1:0] size,
                                              input logic is_unsigned, input logic byte_sel);
    logic [7:0] b;
    b = byte_sel ? hw[15:8] : hw[7:0];
    if (size == SIZE_BYTE)
      return is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
    return is_unsigned ? {16'h0, hw} : {{16{hw[15]}}, hw};
  endfunction

  function automatic logic [15:0] merge_byte(input logic [15:0] hw, input logic byte_sel,
                                             input logic [7:0] b);
    return byte_sel ? {b, hw[7:0]} : {hw[15:8], b};
  endfunction

  assign req_ready = (state == IDLE);
  assign base_addr = {req_q.addr[31:1], 1'b0};
  assign hi_addr   = base_addr + 32'd2;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (is_bad_request(req_size, req_addr[1:0])) state_next = ERROR;
          else if (!req_write)                         state_next = READ_LO;
          else if (req_size == SIZE_BYTE)              state_next = RMW_READ;
          else                                         state_next = WRITE_LO;
        end
      end
      READ_LO:   state_next = (req_q.size == SIZE_WORD) ? READ_HI : IDLE;
      READ_HI:   state_next = IDLE;
      WRITE_LO:  state_next = (req_q.size == SIZE_WORD) ? WRITE_HI : IDLE;
      WRITE_HI:  state_next = IDLE;
      RMW_READ:  state_next = RMW_WRITE;
      RMW_WRITE: state_next = IDLE;
      ERROR:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Bus outputs depend only on state and the captured request (Moore).
  always_comb begin
    data_bus_mode  = BUS_NONE;
    data_bus_addr  = '0;
    data_bus_write = '0;
    unique case (state)
      READ_LO, RMW_READ: begin
        data_bus_mode = BUS_READ;
        data_bus_addr = base_addr;
      end
      READ_HI: begin
        data_bus_mode = BUS_READ;
        data_bus_addr = hi_addr;
      end
      WRITE_LO: begin
        data_bus_mode  = BUS_WRITE;
        data_bus_addr  = base_addr;
        data_bus_write = req_q.wdata[15:0];
      end
      WRITE_HI: begin
        data_bus_mode  = BUS_WRITE;
        data_bus_addr  = hi_addr;
        data_bus_write = req_q.wdata[31:16];
      end
      RMW_WRITE: begin
        data_bus_mode  = BUS_WRITE;
        data_bus_addr  = base_addr;
        data_bus_write = merge_byte(lo_q, req_q.addr[0], req_q.wdata[7:0]);
      end
      default: ;
    endcase
  end

  assign data_bus_select = (data_bus_mode != BUS_NONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_q      <= '0;
      lo_q       <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_next;
      resp_valid <= 1'b0;

      if (req_valid && req_ready)
        req_q <= '{write:       req_write,
                   size:        req_size,
                   is_unsigned: req_unsigned,
                   addr:        req_addr,
                   wdata:       req_wdata};

      // Low half of a word load, or the old halfword of a byte store.
      if (state == READ_LO || state == RMW_READ)
        lo_q <= data_bus_read;

      if (state != IDLE && state_next == IDLE) begin
        resp_valid <= 1'b1;
        resp_error <= (state == ERROR);
        unique case (state)
          READ_LO: resp_rdata <= extend_load(data_bus_read, req_q.size,
                                             req_q.is_unsigned, req_q.addr[0]);
          READ_HI: resp_rdata <= {data_bus_read, lo_q};
          default: resp_rdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_bus_master.sv
// Self-checking bench for data_bus_master: byte-addressed reference memory model,
// directed cases followed by randomized loads/stores.
module tb_data_bus_master;
  import data_bus_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] data_bus_addr;
  logic [1:0]  data_bus_mode;
  logic        data_bus_select;
  logic [15:0] data_bus_write;
  logic [15:0] data_bus_read;

  int errors = 0;
  int checks = 0;

  // Responder: 256 halfwords mapped at 0x4000..0x41FF.
  logic [15:0] mem [0:255];
  // Reference model: the same region viewed as bytes.
  logic [7:0]  ref_mem [0:511];

  logic [49:0] exp_q [$];
  logic [49:0] got_q [$];
  logic        exp_err;
  logic [31:0] exp_rdata;
  int          exp_lat;

  assign data_bus_read = mem[data_bus_addr[8:1]];

  always #5 clk = ~clk;

  data_bus_master dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_error      (resp_error),
    .resp_rdata      (resp_rdata),
    .data_bus_addr   (data_bus_addr),
    .data_bus_mode   (data_bus_mode),
    .data_bus_select (data_bus_select),
    .data_bus_write  (data_bus_write),
    .data_bus_read   (data_bus_read)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [49:0] ent(input logic [1:0] mode, input logic [31:0] a, input logic [15:0] d);
    return {mode, a, d};
  endfunction

  function automatic logic [15:0] ref_hw(input logic [31:0] a);
    logic [8:0] i;
    i = a[8:0];
    return {ref_mem[i + 9'd1], ref_mem[i]};
  endfunction

  task automatic set_hw(input logic [31:0] a, input logic [15:0] v);
    mem[a[8:1]] = v;
    ref_mem[{a[8:1], 1'b0}] = v[7:0];
    ref_mem[{a[8:1], 1'b1}] = v[15:8];
  endtask

  task automatic put_bytes(input logic [31:0] a, input logic [31:0] v, input int n);
    for (int k = 0; k < n; k++) ref_mem[a[8:0] + 9'(k)] = v[8*k +: 8];
  endtask

  // Expected response, latency and bus trace from the load/store rules; stores update ref_mem.
  task automatic model_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] base;
    logic [31:0] v;
    base = a & 32'hFFFF_FFFE;
    exp_q.delete();
    exp_rdata = 32'h0;
    exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    exp_lat = (exp_err || sz == 2'd1 || (sz == 2'd0 && !w)) ? 2 : 3;
    if (exp_err) return;
    if (!w) begin
      if (sz == 2'd0) begin
        v = 32'(ref_mem[a[8:0]]);
        exp_rdata = (u || v < 32'h80) ? v : v - 32'h100;
        exp_q.push_back(ent(BUS_READ, base, 16'h0));
      end else if (sz == 2'd1) begin
        v = 32'(ref_hw(a));
        exp_rdata = (u || v < 32'h8000) ? v : v - 32'h10000;
        exp_q.push_back(ent(BUS_READ, a, 16'h0));
      end else begin
        exp_rdata = {ref_hw(a + 32'd2), ref_hw(a)};
        exp_q.push_back(ent(BUS_READ, a, 16'h0));
        exp_q.push_back(ent(BUS_READ, a + 32'd2, 16'h0));
      end
    end else begin
      if (sz == 2'd0) begin
        exp_q.push_back(ent(BUS_READ, base, 16'h0));
        put_bytes(a, wd, 1);
        exp_q.push_back(ent(BUS_WRITE, base, ref_hw(base)));
      end else if (sz == 2'd1) begin
        put_bytes(a, wd, 2);
        exp_q.push_back(ent(BUS_WRITE, a, wd[15:0]));
      end else begin
        put_bytes(a, wd, 4);
        exp_q.push_back(ent(BUS_WRITE, a, wd[15:0]));
        exp_q.push_back(ent(BUS_WRITE, a + 32'd2, wd[31:16]));
      end
    end
  endtask

  // Issue one request from a negedge with the DUT idle; returns at the resp_valid negedge.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got_rdata);
    int lat;
    model_req(w, sz, u, a, wd);
    check({tag, ".ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got_q.delete();
    lat = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      check({tag, ".select"}, data_bus_select, data_bus_mode != BUS_NONE);
      check({tag, ".addr_bit0"}, data_bus_addr[0], 1'b0);
      if (data_bus_mode != BUS_NONE) begin
        got_q.push_back(ent(data_bus_mode, data_bus_addr,
                            data_bus_mode == BUS_WRITE ? data_bus_write : 16'h0));
        if (data_bus_mode == BUS_WRITE) mem[data_bus_addr[8:1]] = data_bus_write;
      end else begin
        check({tag, ".idle_bus"}, {data_bus_addr, data_bus_write}, 48'h0);
      end
      if (resp_valid) lat = n;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".error"}, resp_error, exp_err);
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".bus_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check({tag, ".bus_txn"}, got_q[k], exp_q[k]);
    got_rdata = resp_rdata;
  endtask

  initial begin
    logic [31:0] r;
    int pulses;
    int bad;

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) set_hw(32'h4000 + 32'(2 * i), 16'($urandom));
    repeat (3) @(negedge clk);
    check("reset.bus", {data_bus_mode, data_bus_select, data_bus_addr, data_bus_write}, 51'h0);
    check("reset.resp", {resp_valid, resp_error, resp_rdata}, 34'h0);
    check("reset.ready", req_ready, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("idle.bus", {data_bus_mode, data_bus_select, data_bus_addr, data_bus_write}, 51'h0);
    check("idle.resp_valid", resp_valid, 1'b0);

    do_req("st_word", 1'b1, SIZE_WORD, 1'b0, 32'h4034, 32'hDEAD_BEEF, r);
    check("st_word.rdata_const", r, 32'h0);

    set_hw(32'h4038, 16'h1234); set_hw(32'h403A, 16'h8765);
    do_req("ld_word", 1'b0, SIZE_WORD, 1'b0, 32'h4038, 32'h0, r);
    check("ld_word.const", r, 32'h8765_1234);

    set_hw(32'h4038, 16'h80AA);
    do_req("ld_byte_s", 1'b0, SIZE_BYTE, 1'b0, 32'h4039, 32'h0, r);
    check("ld_byte_s.const", r, 32'hFFFF_FF80);
    do_req("ld_byte_u", 1'b0, SIZE_BYTE, 1'b1, 32'h4039, 32'h0, r);
    check("ld_byte_u.const", r, 32'h0000_0080);
    do_req("ld_half_s", 1'b0, SIZE_HALF, 1'b0, 32'h4038, 32'h0, r);
    check("ld_half_s.const", r, 32'hFFFF_80AA);

    set_hw(32'h4038, 16'hA1B2);
    do_req("st_byte_lo", 1'b1, SIZE_BYTE, 1'b0, 32'h4038, 32'h0000_005C, r);
    check("st_byte_lo.mem", mem[8'h1C], 16'hA15C);
    set_hw(32'h4038, 16'hA1B2);
    do_req("st_byte_hi", 1'b1, SIZE_BYTE, 1'b0, 32'h4039, 32'h0000_005C, r);
    check("st_byte_hi.mem", mem[8'h1C], 16'h5CB2);

    do_req("err_half", 1'b0, SIZE_HALF, 1'b0, 32'h4035, 32'h0, r);
    do_req("err_word", 1'b0, SIZE_WORD, 1'b0, 32'h4036, 32'h0, r);
    do_req("err_size", 1'b0, SIZE_ILLEGAL, 1'b0, 32'h4038, 32'h0, r);
    check("err_size.flag_const", resp_error, 1'b1);

    // Back-to-back halfword loads: one response every 2 cycles.
    pulses = 0;
    req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_HALF; req_unsigned = 1'b1;
    req_addr = 32'h4038;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check("b2b.valid", resp_valid, (n % 2) == 0);
      if (resp_valid) begin
        pulses++;
        check("b2b.rdata", resp_rdata, {16'h0, ref_hw(32'h4038)});
      end
      if (n == 8) req_valid = 1'b0;
    end
    check("b2b.pulses", pulses, 4);

    for (int t = 0; t < 60; t++) begin
      do_req("rand", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             32'h4000 + 32'($urandom_range(0, 32'h1F0)), $urandom, r);
    end

    // Reset in READ_HI of a word load: bus idles at once and no response follows.
    req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_WORD; req_addr = 32'h4040;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort.in_read_hi", {data_bus_mode, data_bus_addr}, {BUS_READ, 32'h4042});
    reset = 1'b0;
    #1;
    check("abort.bus", {data_bus_mode, data_bus_select, data_bus_addr, data_bus_write}, 51'h0);
    check("abort.ready", req_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("abort.no_resp", pulses, 0);

    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_hw(32'h4000 + 32'(2 * i))) bad++;
    check("final.memory", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
